// File: rtl/change_dispense_ctrl.sv
// Change dispenser: pays out an amount greedily as quarters, dimes and nickels,
// one coin per ack handshake, while tracking each tube's inventory.
module change_dispense_ctrl #(
  parameter int unsigned Q_INIT      = 8,
  parameter int unsigned D_INIT      = 8,
  parameter int unsigned N_INIT      = 8,
  parameter int unsigned ACK_TIMEOUT = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] amount,
  input  logic       eject_ack,
  input  logic       refill,
  input  logic [1:0] refill_sel,
  input  logic [3:0] refill_qty,
  output logic       eject_q,
  output logic       eject_d,
  output logic       eject_n,
  output logic       busy,
  output logic       done,
  output logic [6:0] shortfall,
  output logic       fault,
  output logic [3:0] q_cnt,
  output logic [3:0] d_cnt,
  output logic [3:0] n_cnt
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SELECT, WAIT, DONE} state_t;

  state_t           state;
  logic [6:0]       remaining;
  logic [TMR_W-1:0] timer;

  function automatic logic [6:0] clamp_amount(input logic [6:0] a);
    return (a > 7'd100) ? 7'd100 : a;
  endfunction

  // Tube holds at most 15 coins; the sum is formed one bit wider then clipped.
  function automatic logic [3:0] sat_add(input logic [3:0] cnt, input logic [3:0] qty);
    logic [4:0] sum;
    sum = {1'b0, cnt} + {1'b0, qty};
    return (sum > 5'd15) ? 4'hF : sum[3:0];
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      eject_q   <= 1'b0;
      eject_d   <= 1'b0;
      eject_n   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      shortfall <= 7'd0;
      fault     <= 1'b0;
      q_cnt     <= 4'(Q_INIT);
      d_cnt     <= 4'(D_INIT);
      n_cnt     <= 4'(N_INIT);
      remaining <= 7'd0;
      timer     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (refill) begin
            case (refill_sel)
              2'b00:   n_cnt <= sat_add(n_cnt, refill_qty);
              2'b01:   d_cnt <= sat_add(d_cnt, refill_qty);
              2'b10:   q_cnt <= sat_add(q_cnt, refill_qty);
              default: ;
            endcase
          end
          if (start) begin
            remaining <= clamp_amount(amount);
            fault     <= 1'b0;
            shortfall <= 7'd0;
            busy      <= 1'b1;
            state     <= SELECT;
          end
        end
        SELECT: begin
          timer <= '0;
          if (remaining >= 7'd25 && q_cnt != 4'd0) begin
            eject_q <= 1'b1;
            state   <= WAIT;
          end else if (remaining >= 7'd10 && d_cnt != 4'd0) begin
            eject_d <= 1'b1;
            state   <= WAIT;
          end else if (remaining >= 7'd5 && n_cnt != 4'd0) begin
            eject_n <= 1'b1;
            state   <= WAIT;
          end else begin
            shortfall <= remaining;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        WAIT: begin
          // The coin is only debited once the mechanism confirms the drop.
          if (eject_ack) begin
            eject_q <= 1'b0;
            eject_d <= 1'b0;
            eject_n <= 1'b0;
            if (eject_q) begin
              q_cnt     <= q_cnt - 4'd1;
              remaining <= remaining - 7'd25;
            end else if (eject_d) begin
              d_cnt     <= d_cnt - 4'd1;
              remaining <= remaining - 7'd10;
            end else begin
              n_cnt     <= n_cnt - 4'd1;
              remaining <= remaining - 7'd5;
            end
            state <= SELECT;
          end else if (timer == TMR_LAST) begin
            eject_q   <= 1'b0;
            eject_d   <= 1'b0;
            eject_n   <= 1'b0;
            fault     <= 1'b1;
            shortfall <= remaining;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Scoreboard bench for change_dispense_ctrl: expected coin/done events are queued
// by the stimulus and matched by a monitor as the DUT produces them.
module tb_change_dispense_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [6:0] amount = 7'd0;
  logic       eject_ack = 1'b0;
  logic       refill = 1'b0;
  logic [1:0] refill_sel = 2'b00;
  logic [3:0] refill_qty = 4'd0;
  logic       eject_q, eject_d, eject_n, busy, done, fault;
  logic [6:0] shortfall;
  logic [3:0] q_cnt, d_cnt, n_cnt;

  always #5 clock = ~clock;

  change_dispense_ctrl #(
    .Q_INIT(8), .D_INIT(8), .N_INIT(8), .ACK_TIMEOUT(16)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .amount(amount),
    .eject_ack(eject_ack), .refill(refill), .refill_sel(refill_sel),
    .refill_qty(refill_qty), .eject_q(eject_q), .eject_d(eject_d),
    .eject_n(eject_n), .busy(busy), .done(done), .shortfall(shortfall),
    .fault(fault), .q_cnt(q_cnt), .d_cnt(d_cnt), .n_cnt(n_cnt)
  );

  localparam int K_Q = 0, K_D = 1, K_N = 2, K_DONE = 3;
  typedef struct {int kind; int sf; int flt; int q; int d; int n;} exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  bit ack_en = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_coin(input int k);
    exp_t e;
    e = '{kind: k, sf: 0, flt: 0, q: 0, d: 0, n: 0};
    sb.push_back(e);
  endtask

  task automatic push_done(input int sf, input int flt, input int q, input int d, input int n);
    exp_t e;
    e = '{kind: K_DONE, sf: sf, flt: flt, q: q, d: d, n: n};
    sb.push_back(e);
  endtask

  task automatic pop_check(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      check("unexpected_event", kind, -1);
    end else begin
      e = sb.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == K_DONE && e.kind == K_DONE) begin
        check("done_shortfall", int'(shortfall), e.sf);
        check("done_fault", int'(fault), e.flt);
        check("done_q_cnt", int'(q_cnt), e.q);
        check("done_d_cnt", int'(d_cnt), e.d);
        check("done_n_cnt", int'(n_cnt), e.n);
      end
    end
  endtask

  // Monitor: every solenoid rising edge and every done pulse consumes one entry.
  initial begin
    bit pq, pd, pn;
    pq = 0; pd = 0; pn = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if ((eject_q && !pq) || (eject_d && !pd) || (eject_n && !pn))
          check("eject_onehot", int'(eject_q) + int'(eject_d) + int'(eject_n), 1);
        if (eject_q && !pq) pop_check(K_Q);
        if (eject_d && !pd) pop_check(K_D);
        if (eject_n && !pn) pop_check(K_N);
        if (done) pop_check(K_DONE);
      end
      pq = eject_q; pd = eject_d; pn = eject_n;
    end
  end

  // Coin mechanism model: acknowledges three cycles after a solenoid rises.
  initial begin
    int c;
    c = 0;
    forever begin
      @(posedge clock);
      #1;
      if (eject_q || eject_d || eject_n) begin
        if (ack_en) c++;
        if (c >= 3) eject_ack = 1'b1;
      end else begin
        c = 0;
        eject_ack = 1'b0;
      end
    end
  end

  task automatic pulse_start(input int a);
    @(posedge clock); #1;
    start = 1'b1; amount = 7'(a);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done) begin seen = 1; break; end
    end
    check("done_within_budget", int'(seen), 1);
    @(posedge clock); #1;
  endtask

  task automatic go(input int a);
    pulse_start(a);
    wait_done(200);
  endtask

  task automatic do_refill(input logic [1:0] sel, input logic [3:0] qty);
    @(posedge clock); #1;
    refill = 1'b1; refill_sel = sel; refill_qty = qty;
    @(posedge clock); #1;
    refill = 1'b0;
  endtask

  initial begin
    int hi;
    bit seen;
    #12;
    check("rst_eject_q", int'(eject_q), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_shortfall", int'(shortfall), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_q_cnt", int'(q_cnt), 8);
    check("rst_n_cnt", int'(n_cnt), 8);
    @(posedge clock); #1;
    reset = 1'b0;

    // 90c from full tubes: Q,Q,Q,D,N
    push_coin(K_Q); push_coin(K_Q); push_coin(K_Q); push_coin(K_D); push_coin(K_N);
    push_done(0, 0, 5, 7, 7);
    go(90);

    // 120c clamps to 100c: four quarters
    push_coin(K_Q); push_coin(K_Q); push_coin(K_Q); push_coin(K_Q);
    push_done(0, 0, 1, 7, 7);
    go(120);
    push_coin(K_Q); push_done(0, 0, 0, 7, 7);
    go(25);

    // quarter tube empty: 50c as five dimes
    for (int i = 0; i < 5; i++) push_coin(K_D);
    push_done(0, 0, 0, 2, 7);
    go(50);

    // drain to q=0 d=1 n=1
    for (int i = 0; i < 6; i++) begin
      push_coin(K_N); push_done(0, 0, 0, 2, 6 - i);
      go(5);
    end
    push_coin(K_D); push_done(0, 0, 0, 1, 1);
    go(10);

    // 40c with only one dime and one nickel: 25c short
    push_coin(K_D); push_coin(K_N); push_done(25, 0, 0, 0, 0);
    go(40);

    do_refill(2'b00, 4'd12);
    check("refill_n12", int'(n_cnt), 12);
    do_refill(2'b11, 4'd5);
    check("refill_sel11_q", int'(q_cnt), 0);
    check("refill_sel11_n", int'(n_cnt), 12);

    // 7c: one nickel, 2c residue
    push_coin(K_N); push_done(2, 0, 0, 0, 11);
    go(7);

    // 0c: done on the second edge after the sampling edge, no eject
    push_done(0, 0, 0, 0, 11);
    pulse_start(0);
    @(negedge clock);
    check("zero_done_early", int'(done), 0);
    check("zero_busy", int'(busy), 1);
    @(negedge clock);
    check("zero_done_on_time", int'(done), 1);
    @(posedge clock); #1;

    do_refill(2'b00, 4'd1);
    do_refill(2'b00, 4'd9);
    check("refill_saturate", int'(n_cnt), 15);

    // refill and start on the same cycle: the refilled quarter is used
    push_coin(K_Q); push_done(0, 0, 1, 0, 15);
    @(posedge clock); #1;
    refill = 1'b1; refill_sel = 2'b10; refill_qty = 4'd2; start = 1'b1; amount = 7'd25;
    @(posedge clock); #1;
    refill = 1'b0; start = 1'b0;
    wait_done(200);

    // no ack: timeout after 16 cycles of eject_q
    ack_en = 1'b0;
    push_coin(K_Q); push_done(25, 1, 1, 0, 15);
    pulse_start(25);
    hi = 0; seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      if (eject_q) hi++;
      if (done) begin seen = 1; break; end
    end
    check("timeout_done_seen", int'(seen), 1);
    check("timeout_eject_q_cycles", hi, 16);
    @(posedge clock); #1;
    check("fault_sticky", int'(fault), 1);
    check("timeout_q_unchanged", int'(q_cnt), 1);
    ack_en = 1'b1;
    push_done(0, 0, 1, 0, 15);
    pulse_start(0);
    check("fault_cleared_by_start", int'(fault), 0);
    wait_done(50);

    // refill and start while waiting on an ack are ignored
    ack_en = 1'b0;
    push_coin(K_Q); push_done(0, 0, 0, 0, 15);
    pulse_start(25);
    repeat (3) @(negedge clock);
    @(posedge clock); #1;
    refill = 1'b1; refill_sel = 2'b10; refill_qty = 4'd5; start = 1'b1; amount = 7'd100;
    @(posedge clock); #1;
    refill = 1'b0; start = 1'b0;
    ack_en = 1'b1;
    wait_done(100);
    repeat (5) @(negedge clock);
    check("busy_refill_ignored", int'(q_cnt), 0);
    check("busy_start_ignored", int'(busy), 0);

    // asynchronous reset mid-WAIT
    do_refill(2'b10, 4'd3);
    check("refill_q3", int'(q_cnt), 3);
    ack_en = 1'b0;
    push_coin(K_Q);
    pulse_start(25);
    repeat (4) @(negedge clock);
    check("pre_reset_eject_q", int'(eject_q), 1);
    #1 reset = 1'b1;
    #1;
    check("async_eject_q", int'(eject_q), 0);
    check("async_busy", int'(busy), 0);
    check("async_q_cnt", int'(q_cnt), 8);
    check("async_d_cnt", int'(d_cnt), 8);
    check("async_n_cnt", int'(n_cnt), 8);
    @(posedge clock); #1;
    reset = 1'b0;
    ack_en = 1'b1;
    repeat (3) @(negedge clock);
    check("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
